// File: rtl/grostl_mix_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : grostl_mix_bytes_iter
// Brief    : Iterative Grostl MixBytes engine. Accepts a full state, mixes
//            one 8-byte column per clock through a single column mixer,
//            writes each column back in place, then hands the state on.
// Revision : 1.0 - initial release
// ============================================================================
module grostl_mix_bytes_iter #(
  parameter int NCOLS = 8  // 8 (Grostl-256) or 16 (Grostl-512) only
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [0:NCOLS-1][0:7][7:0]   in_state,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:NCOLS-1][0:7][7:0]   out_state,
  output logic                         busy
);

  localparam int c_col_w = $clog2(NCOLS);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(NCOLS - 1);

  // Circulant base row; row i of the MixBytes matrix is this row rotated
  // right by i positions.
  localparam logic [0:7][7:0] c_base_row =
    {8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h05, 8'h07};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        r_state;
  logic [0:NCOLS-1][0:7][7:0]    r_buf;
  logic [c_col_w-1:0]            r_col;

  logic [0:7][7:0]               w_col_in;
  logic [0:7][7:0]               w_col_mixed;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the small matrix coefficients (2,3,4,5,7); at most
  // two xtime levels deep so the column mixer stays shallow.
  function automatic logic [7:0] mul_coef(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] a2;
    logic [7:0] a4;
    logic [7:0] r;
    a2 = xtime(a);
    a4 = xtime(a2);
    case (k)
      8'h02:   r = a2;
      8'h03:   r = a2 ^ a;
      8'h04:   r = a4;
      8'h05:   r = a4 ^ a;
      8'h07:   r = a4 ^ a2 ^ a;
      default: r = a;
    endcase
    return r;
  endfunction

  // out[i] = XOR_j base[(j-i) mod 8] * in[j]
  function automatic logic [0:7][7:0] mix_col(input logic [0:7][7:0] c);
    logic [0:7][7:0] r;
    logic [2:0]      k;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        k = 3'(j - i);
        r[i] = r[i] ^ mul_coef(c[j], c_base_row[k]);
      end
    end
    return r;
  endfunction

  assign w_col_in    = r_buf[r_col];
  assign w_col_mixed = mix_col(w_col_in);

  // Sequencer: load in IDLE, mix one column per clock in RUN, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_buf   <= in_state;
            r_col   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_buf[r_col] <= w_col_mixed;
          // Wraps to 0 naturally on the last column; only reused after a reload.
          r_col        <= r_col + 1'b1;
          if (r_col == c_last_col) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // No bypass: a new state can only be taken after returning to IDLE.
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign out_state = r_buf;

endmodule
`default_nettype wire
